// File: rtl/vx_banked_local_mem.sv
// vx_banked_local_mem: line-wide local memory with a latency-pipelined, credit-limited Vortex port and a 32-bit generic-bus side port
module vx_banked_local_mem #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 56,
  parameter int DEPTH      = 4096,
  parameter int LATENCY    = 4,
  parameter int RSP_DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  input  logic [31:0]             gb_addr,
  input  logic [31:0]             gb_wdata,
  input  logic [3:0]              gb_byte_en,
  input  logic                    gb_ren,
  input  logic                    gb_wen,
  output logic [31:0]             gb_rdata,
  output logic                    gb_busy,
  output logic                    addr_out_of_bounds
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int LB = $clog2(BW);
  localparam int WB = LB - 2;
  localparam int IW = $clog2(DEPTH);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {GB_IDLE, GB_ACCESS, GB_DONE} gb_state_t;
  gb_state_t state, state_n;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] fd [RSP_DEPTH];
  logic [TAG_WIDTH-1:0] ft [RSP_DEPTH];
  logic [LATENCY-1:0] pv;
  logic [LATENCY-1:0][ADDR_WIDTH-1:0] pa;
  logic [LATENCY-1:0][TAG_WIDTH-1:0] pt;
  logic [PW:0] wp, rp;
  logic [CW-1:0] inflight;
  logic accept, rd_acc, pop, gb_grant, vx_in, st_in, gb_in, gb_we, gb_re;
  logic [ADDR_WIDTH-1:0] gb_line;
  logic [WB-1:0] gb_word;
  logic [DATA_WIDTH-1:0] st_data, vx_mask, gb_mask, gb_wide;
  logic unused_ok;
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < (ADDR_WIDTH+1)'(DEPTH);
  endfunction
  assign unused_ok = &{1'b0, gb_addr[1:0]};
  assign gb_line = gb_addr[LB +: ADDR_WIDTH];
  assign gb_word = gb_addr[2 +: WB];
  assign mem_req_ready = !reset && !gb_grant && inflight < CW'(RSP_DEPTH);
  assign accept = mem_req_valid && mem_req_ready;
  assign rd_acc = accept && !mem_req_rw;
  assign pop = mem_rsp_valid && mem_rsp_ready;
  assign vx_in = in_range(mem_req_addr);
  assign st_in = in_range(pa[LATENCY-1]);
  assign gb_in = in_range(gb_line);
  assign gb_we = gb_grant && gb_wen;
  assign gb_re = gb_grant && gb_ren && !gb_wen;
  assign st_data = st_in ? mem[pa[LATENCY-1][IW-1:0]] : '0;
  assign gb_wide = DATA_WIDTH'(gb_wdata) << {gb_word, 5'b00000};
  assign gb_mask = DATA_WIDTH'({{8{gb_byte_en[3]}}, {8{gb_byte_en[2]}}, {8{gb_byte_en[1]}}, {8{gb_byte_en[0]}}}) << {gb_word, 5'b00000};
  assign mem_rsp_valid = wp != rp;
  assign mem_rsp_data = mem_rsp_valid ? fd[rp[PW-1:0]] : '0;
  assign mem_rsp_tag = mem_rsp_valid ? ft[rp[PW-1:0]] : '0;
  always_comb begin
    vx_mask = '0;
    for (int i = 0; i < BW; i++) vx_mask[i*8 +: 8] = {8{mem_req_byteen[i]}};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= GB_IDLE;
    else state <= state_n;
  always_comb state_n = state == GB_IDLE ? ((gb_ren || gb_wen) && !accept ? GB_ACCESS : GB_IDLE) :
                        state == GB_ACCESS ? GB_DONE : GB_IDLE;
  always_comb begin
    gb_grant = state == GB_ACCESS;
    gb_busy = (gb_ren || gb_wen) && state != GB_DONE;
  end
  always_ff @(posedge clk) begin
    if (accept && mem_req_rw && vx_in) mem[mem_req_addr[IW-1:0]] <= (mem[mem_req_addr[IW-1:0]] & ~vx_mask) | (mem_req_data & vx_mask);
    if (gb_we && gb_in) mem[gb_line[IW-1:0]] <= (mem[gb_line[IW-1:0]] & ~gb_mask) | (gb_wide & gb_mask);
    if (pv[LATENCY-1]) begin
      fd[wp[PW-1:0]] <= st_data;
      ft[wp[PW-1:0]] <= pt[LATENCY-1];
    end
    for (int i = LATENCY - 1; i > 0; i--) begin
      pa[i] <= pa[i-1];
      pt[i] <= pt[i-1];
    end
    pa[0] <= mem_req_addr;
    pt[0] <= mem_req_tag;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pv <= '0;
      wp <= '0;
      rp <= '0;
      inflight <= '0;
      gb_rdata <= '0;
      addr_out_of_bounds <= 1'b0;
    end else begin
      pv <= (pv << 1) | LATENCY'(rd_acc);
      if (pv[LATENCY-1]) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      inflight <= inflight + CW'(rd_acc) - CW'(pop);
      if (gb_re) gb_rdata <= gb_in ? mem[gb_line[IW-1:0]][{gb_word, 5'b00000} +: 32] : '0;
      if ((accept && !vx_in) || (gb_grant && (gb_ren || gb_wen) && !gb_in)) addr_out_of_bounds <= 1'b1;
    end
endmodule

// File: tb/tb_vx_banked_local_mem.sv
// tb_vx_banked_local_mem: scoreboard bench with a line-array reference model and randomized traffic
module tb_vx_banked_local_mem;
  localparam int DW = 512, AW = 26, TW = 56, DEPTH = 4096, LATENCY = 4, RSP_DEPTH = 8;
  typedef struct {logic [DW-1:0] d; logic [TW-1:0] t; int line;} exp_t;
  logic clk, reset;
  logic mem_req_valid, mem_req_rw, mem_req_ready, mem_rsp_valid, mem_rsp_ready;
  logic [DW/8-1:0] mem_req_byteen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data, mem_rsp_data;
  logic [TW-1:0] mem_req_tag, mem_rsp_tag;
  logic [31:0] gb_addr, gb_wdata, gb_rdata;
  logic [3:0] gb_byte_en;
  logic gb_ren, gb_wen, gb_busy, addr_out_of_bounds;
  exp_t sb[$];
  logic [DW-1:0] model [32];
  bit oob_exp, rnd_rdy;
  int checks, errors;
  vx_banked_local_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DEPTH(DEPTH),
    .LATENCY(LATENCY), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .reset(reset), .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_byte_en(gb_byte_en), .gb_ren(gb_ren),
    .gb_wen(gb_wen), .gb_rdata(gb_rdata), .gb_busy(gb_busy), .addr_out_of_bounds(addr_out_of_bounds));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic logic [DW-1:0] r512();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  function automatic bit pending(input int ln);
    foreach (sb[i]) if (sb[i].line == ln) return 1;
    return 0;
  endfunction
  task automatic vx_op(input logic rw, input logic [AW-1:0] a, input logic [DW/8-1:0] be,
                       input logic [DW-1:0] d, input logic [TW-1:0] t, output int waits);
    logic acc;
    waits = 0;
    acc = 0;
    mem_req_valid = 1; mem_req_rw = rw; mem_req_addr = a; mem_req_byteen = be;
    mem_req_data = d; mem_req_tag = t;
    while (!acc && waits < 100) begin
      @(negedge clk);
      acc = mem_req_ready;
      if (!acc) waits++;
      @(posedge clk);
      #1;
    end
    mem_req_valid = 0;
    if (!acc) chk("req_accept_timeout", 0, 1);
    else if (int'(a) >= DEPTH) begin
      oob_exp = 1;
      if (!rw) sb.push_back('{'0, t, int'(a)});
    end else if (rw) begin
      for (int i = 0; i < DW / 8; i++) if (be[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
    end else sb.push_back('{model[a], t, int'(a)});
  endtask
  task automatic gb_op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output int cyc, output logic [31:0] rd);
    gb_ren = r; gb_wen = w; gb_addr = a; gb_wdata = d; gb_byte_en = be;
    cyc = 0;
    @(negedge clk);
    while (gb_busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    rd = gb_rdata;
    if (cyc >= 50) chk("gb_timeout", 0, 1);
    else if (w) begin
      for (int b = 0; b < 4; b++) if (be[b]) model[a[10:6]][a[5:2]*32 + b*8 +: 8] = d[b*8 +: 8];
    end
    @(posedge clk);
    #1;
    gb_ren = 0; gb_wen = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    mem_rsp_ready = 1;
    while ((sb.size() != 0 || mem_rsp_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) chk("drain_timeout", 0, 1);
  endtask
  initial begin
    logic hv;
    logic [DW-1:0] hd;
    logic [TW-1:0] ht;
    exp_t e;
    hv = 0;
    forever begin
      @(negedge clk);
      if (reset) hv = 0;
      else begin
        if (hv) begin
          chk("hold_valid", mem_rsp_valid, 1);
          chk("hold_data", mem_rsp_data, hd);
          chk("hold_tag", mem_rsp_tag, ht);
        end
        if (mem_rsp_valid && mem_rsp_ready) begin
          if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
          else begin
            e = sb.pop_front();
            chk("rsp_tag", mem_rsp_tag, e.t);
            chk("rsp_data", mem_rsp_data, e.d);
          end
        end
        hv = mem_rsp_valid && !mem_rsp_ready;
        hd = mem_rsp_data;
        ht = mem_rsp_tag;
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) mem_rsp_ready = ($urandom % 4) != 0;
  end
  initial begin
    int w, cyc, lat, k, ln, wd, ga;
    logic [31:0] rd;
    logic [TW-1:0] tg;
    checks = 0; errors = 0; oob_exp = 0; rnd_rdy = 0; tg = 100;
    mem_req_valid = 0; mem_req_rw = 0; mem_req_byteen = '0; mem_req_addr = '0;
    mem_req_data = '0; mem_req_tag = '0; mem_rsp_ready = 0;
    gb_addr = 0; gb_wdata = 0; gb_byte_en = 0; gb_ren = 0; gb_wen = 0;
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", mem_req_ready, 0);
    chk("rst_rsp_valid", mem_rsp_valid, 0);
    chk("rst_rsp_data", mem_rsp_data, 0);
    chk("rst_rsp_tag", mem_rsp_tag, 0);
    chk("rst_gb_rdata", gb_rdata, 0);
    chk("rst_gb_busy", gb_busy, 0);
    chk("rst_oob", addr_out_of_bounds, 0);
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("ready_after_reset", mem_req_ready, 1);
    mem_rsp_ready = 1;
    for (int l = 0; l < 32; l++) vx_op(1, AW'(l), '1, r512(), 0, w);
    vx_op(1, 26'h10, '1, {64{8'hA5}}, 0, w);
    vx_op(0, 26'h10, '0, '0, 56'h3, w);
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (mem_rsp_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("read_latency", lat, LATENCY);
    drain();
    mem_rsp_ready = 0;
    for (int t = 0; t < 8; t++) vx_op(0, AW'(t), '0, '0, TW'(t), w);
    @(negedge clk);
    chk("full_ready_low", mem_req_ready, 0);
    repeat (LATENCY + 2) @(posedge clk);
    #1 mem_rsp_ready = 1;
    @(negedge clk);
    chk("ready_before_pop", mem_req_ready, 0);
    @(negedge clk);
    chk("ready_after_pop", mem_req_ready, 1);
    drain();
    vx_op(1, 26'd5, '1, '0, 0, w);
    vx_op(1, 26'd5, 64'h1, 512'hFF, 0, w);
    vx_op(0, 26'd5, '0, '0, 56'h55, w);
    drain();
    gb_op(0, 1, 32'h44, 32'hDEADBEEF, 4'hF, cyc, rd);
    chk("gb_wr_cycles", cyc, 2);
    vx_op(0, 26'd1, '0, '0, 56'h9, w);
    drain();
    gb_op(1, 0, 32'h44, 0, 0, cyc, rd);
    chk("gb_rd_data", rd, 32'hDEADBEEF);
    chk("gb_rd_cycles", cyc, 2);
    fork
      begin
        vx_op(0, 26'd2, '0, '0, 56'd20, w);
        @(posedge clk);
        #1;
        vx_op(0, 26'd3, '0, '0, 56'd21, w);
        chk("conflict_vx_waits", w, 1);
      end
      begin
        gb_op(0, 1, 32'h1C8, 32'h12345678, 4'hF, cyc, rd);
        chk("conflict_gb_cycles", cyc, 3);
      end
    join
    drain();
    chk("oob_before", addr_out_of_bounds, 0);
    vx_op(0, AW'(DEPTH), '0, '0, 56'h77, w);
    drain();
    @(negedge clk);
    chk("oob_set", addr_out_of_bounds, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("oob_sticky", addr_out_of_bounds, 1);
    mem_rsp_ready = 0;
    for (int t = 0; t < 4; t++) vx_op(0, AW'(8 + t), '0, '0, TW'(30 + t), w);
    repeat (LATENCY + 1) @(posedge clk);
    @(negedge clk);
    chk("burst_valid", mem_rsp_valid, 1);
    @(posedge clk);
    #3 reset = 1;
    #1;
    chk("midrst_rsp_valid", mem_rsp_valid, 0);
    chk("midrst_oob", addr_out_of_bounds, 0);
    chk("midrst_req_ready", mem_req_ready, 0);
    sb.delete();
    oob_exp = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    mem_rsp_ready = 1;
    @(negedge clk);
    chk("post_rst_ready", mem_req_ready, 1);
    chk("post_rst_valid", mem_rsp_valid, 0);
    rnd_rdy = 1;
    for (int n = 0; n < 400; n++) begin
      k = $urandom % 16;
      ln = $urandom % 32;
      wd = $urandom % 16;
      ga = ln * 64 + wd * 4;
      tg = tg + 1;
      if (k < 6 || (k < 12 && pending(ln))) vx_op(0, AW'(ln), '0, '0, tg, w);
      else if (k < 11) vx_op(1, AW'(ln), {$urandom, $urandom}, r512(), 0, w);
      else if (k == 11) gb_op(0, 1, 32'(ga), $urandom, 4'($urandom), cyc, rd);
      else if (k == 12) begin
        gb_op(1, 0, 32'(ga), 0, 0, cyc, rd);
        chk("gb_rnd_rdata", rd, model[ln][wd*32 +: 32]);
        chk("gb_rnd_cycles", cyc, 2);
      end else if (k == 13) vx_op(1'($urandom), AW'(DEPTH + ($urandom % 8)), {$urandom, $urandom}, r512(), tg, w);
      else begin
        @(posedge clk);
        #1;
      end
    end
    rnd_rdy = 0;
    drain();
    @(negedge clk);
    chk("final_oob", addr_out_of_bounds, oob_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
